// File: rtl/clock_divide_2_pkg.sv
// Shared helpers for the clock divider: derives phase split from the division ratio.
`timescale 1ns/1ps
package clock_divide_2_pkg;

   // Odd ratios give the extra cycle to the high phase.
   function automatic int high_count(input int divide);
      return (divide + 1) / 2;
   endfunction

endpackage

// File: rtl/clock_divide_2.sv
// Integer clock divider: phase counter plus a registered, glitch-free output.
`timescale 1ns/1ps
module clock_divide_2
   import clock_divide_2_pkg::*;
#(
   parameter int DIVIDE = 2
) (
   input  logic clk_in,
   input  logic reset,
   output logic clk_out
);

   // Guarded so an invalid ratio reaches the explicit error below rather than a zero-width vector.
   localparam int CNT_W    = (DIVIDE < 2) ? 1 : $clog2(DIVIDE);
   localparam int HIGH_CNT = high_count(DIVIDE);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDE - 1);
   localparam logic [CNT_W-1:0] HIGH_LIM = CNT_W'(HIGH_CNT);

   if (DIVIDE < 2) begin : g_bad_divide
      $error("clock_divide_2: DIVIDE must be at least 2");
   end

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             clk_out_q;
   logic             clk_out_d;

   // cnt_q is the phase the output enters at this edge, so a cleared counter yields a rise on the first edge.
   always_comb begin
      cnt_d     = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
      clk_out_d = (cnt_q < HIGH_LIM);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clock_divide_2.sv
// Directed bench for clock_divide_2 at DIVIDE = 2, 3 and 4 sharing one clock and reset.
`timescale 1ns/1ps
module tb_clock_divide_2;

   logic clk_in;
   logic reset;
   logic out_d2;
   logic out_d3;
   logic out_d4;

   int  checks   = 0;
   int  failures = 0;
   time last_rise = 0;

   logic pat_d2 [2] = '{1'b1, 1'b0};
   logic pat_d3 [3] = '{1'b1, 1'b1, 1'b0};
   logic pat_d4 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

   clock_divide_2 #(.DIVIDE(2)) dut_d2 (.clk_in(clk_in), .reset(reset), .clk_out(out_d2));
   clock_divide_2 #(.DIVIDE(3)) dut_d3 (.clk_in(clk_in), .reset(reset), .clk_out(out_d3));
   clock_divide_2 #(.DIVIDE(4)) dut_d4 (.clk_in(clk_in), .reset(reset), .clk_out(out_d4));

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) last_rise = $time;

   task automatic check_output(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_count(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_edge(input string tag);
      if ($time != 0) begin
         checks++;
         assert ($time == last_rise) else begin
            failures++;
            $error("[TB] FAIL %s observed=change@%0t expected=change@%0t", tag, $time, last_rise);
         end
      end
   endtask

   always @(out_d2) check_edge("glitch_d2");
   always @(out_d3) check_edge("glitch_d3");
   always @(out_d4) check_edge("glitch_d4");

   task automatic check_all(input string tag, input logic e2, input logic e3, input logic e4);
      check_output({tag, "_d2"}, out_d2, e2);
      check_output({tag, "_d3"}, out_d3, e3);
      check_output({tag, "_d4"}, out_d4, e4);
   endtask

   // Steps n edges after a reset release; phase index restarts at 0 on the first edge.
   task automatic apply_stimulus(input string tag, input int n);
      int highs_d4 = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
         check_all(tag, pat_d2[i % 2], pat_d3[i % 3], pat_d4[i % 4]);
         if (out_d4 === 1'b1) highs_d4++;
         if ((i % 4) == 3) begin
            check_count({tag, "_highs_d4"}, highs_d4, 2);
            highs_d4 = 0;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      #6;
      check_all("reset", 1'b0, 1'b0, 1'b0);
      #6;
      check_all("reset_12ns", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #2;
      check_all("pre_first_edge", 1'b0, 1'b0, 1'b0);

      apply_stimulus("run", 41);

      // Last step left every output high; a one-cycle reset must pull all low.
      reset = 1'b1;
      @(posedge clk_in);
      #1;
      check_all("mid_reset", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      apply_stimulus("resume", 3);

      // Now d3 and d4 sit in their low phase when reset is held.
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_in);
         #1;
         check_all("held_reset", 1'b0, 1'b0, 1'b0);
      end
      reset = 1'b0;

      apply_stimulus("after_held", 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
